load_store_unit: RTL and testbench

Memory-access stage between the single-cycle datapath and a variable-latency data memory. Accepts one load or store per transaction from the datapath (ALU result as address, second register operand as store data), produces aligned word requests with byte enables, and returns sign/zero-extended load data. Holds the datapath stalled until the memory acknowledges or a timeout fires. Flags misaligned, illegal-width and timed-out accesses.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 width
// codes and the predicate that rejects an access before it reaches memory.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // High when the access must be answered with an error and never issued.
    function automatic logic lsu_bad_access(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            LSU_B, LSU_BU: bad = 1'b0;
            LSU_H, LSU_HU: bad = addr_lo[0];
            LSU_W:         bad = (addr_lo != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte enables going
// out, byte/half extraction with sign or zero extension coming back.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              write,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_lanes,
    output logic [DATA_W-1:0] rdata_ext
);

    function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] v, input logic sgn);
        return {{(DATA_W-8){sgn & v[7]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] v, input logic sgn);
        return {{(DATA_W-16){sgn & v[15]}}, v};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            LSU_B:   rdata_ext = extend_byte(byte_sel, 1'b1);
            LSU_BU:  rdata_ext = extend_byte(byte_sel, 1'b0);
            LSU_H:   rdata_ext = extend_half(half_sel, 1'b1);
            LSU_HU:  rdata_ext = extend_half(half_sel, 1'b0);
            default: rdata_ext = rdata;
        endcase
    end

    // Loads always present all four enables; only stores narrow them.
    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        if (write) begin
            case (funct3[1:0])
                2'b00: begin
                    wdata_lanes = {4{wdata[7:0]}};
                    be          = 4'b0001 << addr_lo;
                end
                2'b01: begin
                    wdata_lanes = {2{wdata[15:0]}};
                    be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_lanes = wdata;
                    be          = 4'b1111;
                end
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: latches one load/store, drives a word-aligned request to a
// variable-latency memory, and returns extended data or an error after ack/timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        accept, capture, in_access;

    logic              write_p0;
    logic [2:0]        funct3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] data_p0;

    logic [3:0]        be_w;
    logic [DATA_W-1:0] lanes_w;
    logic [DATA_W-1:0] ext_w;

    assign in_access = (state_q == ST_ACCESS);
    assign accept    = (state_q == ST_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = 8'd0;
                    if (lsu_bad_access(req_funct3, req_addr[1:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack on the final allowed cycle still counts as success.
                if (mem_ack) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    capture = 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Stage p0: latched request and captured response data
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0  <= req_write;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
            data_p0   <= '0;
        end else if (capture) begin
            data_p0   <= write_p0 ? '0 : ext_w;
        end
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .write       (write_p0),
        .funct3      (funct3_p0),
        .addr_lo     (addr_p0[1:0]),
        .wdata       (wdata_p0),
        .rdata       (mem_rdata),
        .be          (be_w),
        .wdata_lanes (lanes_w),
        .rdata_ext   (ext_w)
    );

    // Memory-side outputs are gated so they read zero outside ACCESS.
    assign req_ready = (state_q == ST_IDLE);
    assign stall     = accept || in_access;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_data  = rsp_valid ? data_p0 : '0;
    assign mem_req   = in_access;
    assign mem_we    = in_access && write_p0;
    assign mem_addr  = in_access ? {addr_p0[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be    = in_access ? be_w : 4'b0000;
    assign mem_wdata = in_access ? lanes_w : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model of
// lane steering, extension, error rules and ack/timeout timing.
module tb_load_store_unit;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes, 0 for an unsupported funct3.
    function automatic int model_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
        int sz = model_size(f3);
        if (sz == 0) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int sz = model_size(f3);
        int off = a % 4;
        logic [31:0] mask, val;
        if (sz == 4) return rd;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        val  = (rd >> (8 * off)) & mask;
        if (f3[2] == 1'b0 && val[8*sz-1]) val = val | ~mask;
        return val;
    endfunction

    // One complete transaction from IDLE back to IDLE; ack_dly is the ACCESS
    // cycle index carrying mem_ack, or negative for no ack at all.
    task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
        int sz = model_size(f3);
        int off = a % 4;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        bit ok = 1'b0;
        exp_be = 4'hF;
        exp_wd = wd;
        if (wr && sz == 1) begin
            exp_be = 4'(1 << off);
            exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        end else if (wr && sz == 2) begin
            exp_be = (off >= 2) ? 4'hC : 4'h3;
            exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        end

        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        #1;
        chk("stall_accept", 32'(stall), 32'd1);
        step();
        req_valid = 1'b0;
        req_wdata = $urandom;
        #1;
        if (model_bad(f3, a)) begin
            chk("err_no_memreq", 32'(mem_req), 32'd0);
            chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("err_rsp_err", 32'(rsp_err), 32'd1);
            chk("err_rsp_data", rsp_data, 32'd0);
            chk("err_stall", 32'(stall), 32'd0);
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                chk("acc_mem_req", 32'(mem_req), 32'd1);
                chk("acc_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("acc_mem_be", 32'(mem_be), 32'(exp_be));
                chk("acc_mem_we", 32'(mem_we), 32'(wr));
                if (wr) chk("acc_mem_wdata", mem_wdata, exp_wd);
                chk("acc_stall", 32'(stall), 32'd1);
                chk("acc_no_rsp", 32'(rsp_valid), 32'd0);
                if (k == ack_dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                step();
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                if (k == ack_dly) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err", 32'(rsp_err), 32'(!ok));
            chk("rsp_data", rsp_data, (ok && !wr) ? model_load(f3, a, rd) : 32'd0);
            chk("rsp_stall", 32'(stall), 32'd0);
            chk("rsp_memreq_drop", 32'(mem_req), 32'd0);
        end
        step();
        chk("back_idle_rsp", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        logic wr;
        int dly;

        #2;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Directed cases
        do_txn(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0);
        do_txn(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h00F0_0000, 0);
        chk("lb_known", model_load(3'b000, 32'h102, 32'h00F0_0000), 32'hFFFF_FFF0);
        do_txn(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h00F0_0000, 2);
        do_txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 1);
        do_txn(1'b0, 3'b010, 32'h0000_0201, 32'h0, 32'h0, 0);
        do_txn(1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'h0, 0);
        do_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1234_5678, -1);
        do_txn(1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'h8765_4321, TIMEOUT - 1);
        do_txn(1'b1, 3'b001, 32'h0000_0106, 32'hDEAD_BEEF, 32'h0, 3);

        // mem_ack while idle must not produce a response
        mem_ack = 1'b1;
        step();
        chk("idle_ack_ignored", 32'(rsp_valid), 32'd0);
        chk("idle_ack_ready", 32'(req_ready), 32'd1);
        mem_ack = 1'b0;

        // Asynchronous reset in the middle of ACCESS
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
        step();
        req_valid = 1'b0;
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd1);
        chk("async_rst_rsp", 32'(rsp_valid), 32'd0);
        step();
        reset = 1'b1;
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk("post_rst_rsp2", 32'(rsp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Back-to-back requests with an always-acking memory: three-cycle cadence
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        for (int c = 0; c < 9; c++) begin
            chk("b2b_ready", 32'(req_ready), 32'(c % 3 == 0));
            chk("b2b_mem_req", 32'(mem_req), 32'(c % 3 == 1));
            chk("b2b_rsp_valid", 32'(rsp_valid), 32'(c % 3 == 2));
            chk("b2b_stall", 32'(stall), 32'(c % 3 != 2));
            if (c % 3 == 2) chk("b2b_rsp_data", rsp_data, 32'hCAFE_F00D);
            step();
        end
        req_valid = 1'b0;
        mem_ack = 1'b0;
        // c=9 lands in IDLE again
        step();
        step();
        chk("b2b_drain_ready", 32'(req_ready), 32'd1);

        // Randomized transactions
        for (int t = 0; t < 200; t++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (wr && (f3 == 3'b100 || f3 == 3'b101)) f3 = f3 - 3'd4;
            if ($urandom_range(0, 3) == 0) dly = -1;
            else dly = $urandom_range(0, TIMEOUT + 3);
            do_txn(wr, f3, 32'($urandom), 32'($urandom), 32'($urandom), dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
